// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package seq_decoder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Upper bound on decoder width supported by the onehot helper.
  localparam int MAX_OUTPUTS = 32;

  // One-hot vector with bit idx set; all-zero when idx is outside 0..n-1.
  function automatic logic [MAX_OUTPUTS-1:0] onehot(input logic [7:0] idx, input int n);
    logic [MAX_OUTPUTS-1:0] r;
    r = '0;
    if (int'(idx) < n) begin
      r = MAX_OUTPUTS'(1) << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index -> one-hot decoder with enable; the parent registers it.
module onehot_decoder
  import seq_decoder_pkg::*;
#(
  parameter int IDX_WIDTH = 2,
  parameter int N         = 4
) (
  input  logic                 en,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [N-1:0]         onehot_out
);

  logic [N-1:0] full;

  assign full = N'(onehot(8'(idx), N));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign onehot_out[gi] = en & full[gi];
    end
  endgenerate

endmodule

// File: rtl/sequenced_decoder.sv
// Registered one-hot decoder that walks a run of consecutive outputs,
// holding each for DWELL cycles, under a valid/ready command handshake.
// Optional feature: define SEQ_DECODER_RANGE_ERR_EN to get a sticky err
// flag on out-of-range commands; otherwise err is tied low.
module sequenced_decoder
  import seq_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int NUM_OUTPUTS = 4,
  parameter int DWELL       = 1,
  parameter int LEN_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic                   hold,
  input  logic                   abort,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  idx_reg, idx_next;
  logic [DW-1:0]          dwell_cnt_reg, dwell_cnt_next;
  logic [LEN_WIDTH-1:0]   remain_reg, remain_next;
  logic                   done_next;
  logic                   err_reg, err_next;
  logic [NUM_OUTPUTS-1:0] out_reg, dec_out;
  logic                   ready_reg, busy_reg, done_reg;
  logic                   addr_ok;

  assign addr_ok = ({1'b0, cmd_addr} < (ADDR_WIDTH+1)'(NUM_OUTPUTS));

  // Next-state logic: accept, dwell countdown, advance with wrap, finish/abort.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    dwell_cnt_next = dwell_cnt_reg;
    remain_next    = remain_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (addr_ok) begin
            state_next     = ACTIVE;
            idx_next       = cmd_addr;
            dwell_cnt_next = DW'(DWELL - 1);
            remain_next    = cmd_len;
          end else begin
`ifdef SEQ_DECODER_RANGE_ERR_EN
            err_next = 1'b1;
`endif
          end
        end
      end
      ACTIVE: begin
        // abort takes priority over hold and over normal completion
        if (abort) begin
          state_next = IDLE;
        end else if (!hold) begin
          if (dwell_cnt_reg != '0) begin
            dwell_cnt_next = dwell_cnt_reg - DW'(1);
          end else if (remain_reg != '0) begin
            idx_next       = (idx_reg == ADDR_WIDTH'(NUM_OUTPUTS - 1)) ? '0
                                                                       : idx_reg + ADDR_WIDTH'(1);
            dwell_cnt_next = DW'(DWELL - 1);
            remain_next    = remain_reg - LEN_WIDTH'(1);
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode the upcoming index so out is registered alongside the state.
  onehot_decoder #(
    .IDX_WIDTH (ADDR_WIDTH),
    .N         (NUM_OUTPUTS)
  ) u_dec (
    .en         (state_next == ACTIVE),
    .idx        (idx_next),
    .onehot_out (dec_out)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      dwell_cnt_reg <= '0;
      remain_reg    <= '0;
      out_reg       <= '0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      dwell_cnt_reg <= dwell_cnt_next;
      remain_reg    <= remain_next;
      out_reg       <= dec_out;
      ready_reg     <= (state_next == IDLE);
      busy_reg      <= (state_next == ACTIVE);
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign out       = out_reg;
  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sequenced_decoder.sv
// Directed bench for sequenced_decoder (DWELL=2, 4 outputs) plus a
// 3-output instance for the out-of-range path.
module tb_sequenced_decoder;

  logic       clk;
  logic       reset;
  logic       cmd_valid, hold, abort;
  logic [1:0] cmd_addr, cmd_len;
  logic       cmd_ready, busy, done, err;
  logic [3:0] out;

  logic       cmd_valid3;
  logic [1:0] cmd_addr3;
  logic       cmd_ready3, busy3, done3, err3;
  logic [2:0] out3;

  int n_cmp;
  int n_bad;
  logic exp_err;

  sequenced_decoder #(.ADDR_WIDTH(2), .NUM_OUTPUTS(4), .DWELL(2), .LEN_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .hold(hold), .abort(abort),
    .out(out), .busy(busy), .done(done), .err(err)
  );

  sequenced_decoder #(.ADDR_WIDTH(2), .NUM_OUTPUTS(3), .DWELL(2), .LEN_WIDTH(2)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_addr(cmd_addr3), .cmd_len(2'd0), .hold(1'b0), .abort(1'b0),
    .out(out3), .busy(busy3), .done(done3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] scan_exp [6];
    logic [3:0] hold_exp [7];
    n_cmp = 0;
    n_bad = 0;
`ifdef SEQ_DECODER_RANGE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    scan_exp = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    hold_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd0;
    hold = 1'b0; abort = 1'b0; cmd_valid3 = 1'b0; cmd_addr3 = 2'd0;
    step(); step();
    reset = 1'b0;
    $display("txn reset");
    check("rst_out", 32'(out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    step();

    // Single: addr=2, len=0
    $display("txn single addr=2 len=0");
    cmd_valid = 1'b1; cmd_addr = 2'd2; cmd_len = 2'd0;
    step();
    cmd_valid = 1'b0;
    check("single_out0", 32'(out), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    check("single_ready", 32'(cmd_ready), 32'h0);
    step();
    check("single_out1", 32'(out), 32'h4);
    check("single_done0", 32'(done), 32'h0);
    step();
    check("single_out_end", 32'(out), 32'h0);
    check("single_done", 32'(done), 32'h1);
    check("single_ready_end", 32'(cmd_ready), 32'h1);
    step();
    check("single_done_clr", 32'(done), 32'h0);

    // Scan with wrap: addr=3, len=2, then back-to-back command in done cycle
    $display("txn scan addr=3 len=2");
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 2'd2;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("scan_out%0d", i), 32'(out), 32'(scan_exp[i]));
      check($sformatf("scan_done%0d", i), 32'(done), 32'h0);
      step();
    end
    check("scan_end_out", 32'(out), 32'h0);
    check("scan_end_done", 32'(done), 32'h1);
    check("scan_end_ready", 32'(cmd_ready), 32'h1);
    $display("txn back-to-back addr=1 len=0");
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 2'd0;
    step();
    cmd_valid = 1'b0;
    check("b2b_out", 32'(out), 32'h2);
    check("b2b_busy", 32'(busy), 32'h1);
    step(); step();
    check("b2b_done", 32'(done), 32'h1);
    step();

    // Hold then abort: addr=0, len=3
    $display("txn hold/abort addr=0 len=3");
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 2'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("hold_out%0d", i), 32'(out), 32'(hold_exp[i]));
      hold = (i >= 2 && i <= 4);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_out", 32'(out), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_ready", 32'(cmd_ready), 32'h1);
    step();
    check("abort_done_after", 32'(done), 32'h0);
    check("abort_out_after", 32'(out), 32'h0);

    // Out-of-range on the 3-output instance
    $display("txn range addr=3 on 3-output instance");
    check("range_ready", 32'(cmd_ready3), 32'h1);
    cmd_valid3 = 1'b1; cmd_addr3 = 2'd3;
    step();
    cmd_valid3 = 1'b0;
    check("range_out", 32'(out3), 32'h0);
    check("range_busy", 32'(busy3), 32'h0);
    check("range_err", 32'(err3), 32'(exp_err));
    check("range_ready_after", 32'(cmd_ready3), 32'h1);
    step();
    check("range_done", 32'(done3), 32'h0);
    check("range_err_sticky", 32'(err3), 32'(exp_err));
    $display("txn legal addr=2 on 3-output instance");
    cmd_valid3 = 1'b1; cmd_addr3 = 2'd2;
    step();
    cmd_valid3 = 1'b0;
    check("range_legal_out", 32'(out3), 32'h4);
    check("range_err_kept", 32'(err3), 32'(exp_err));
    step(); step(); step();

    // Reset mid-run on a len=3 scan
    $display("txn reset mid-run addr=0 len=3");
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 2'd3;
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("midrun_out_before", 32'(out), 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrun_out", 32'(out), 32'h0);
    check("midrun_busy", 32'(busy), 32'h0);
    check("midrun_done", 32'(done), 32'h0);
    check("midrun_ready", 32'(cmd_ready), 32'h1);
    check("midrun_err3_cleared", 32'(err3), 32'h0);
    step();
    check("midrun_done_after", 32'(done), 32'h0);
    check("midrun_out_after", 32'(out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
